// File: rtl/nn_ctrl_pkg.sv
// Shared types for the NN control sequencer.
// Opcodes, ALU selects, FSM states and the control word.
package nn_ctrl_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_MUL  = 4'h2;
  localparam logic [3:0] OP_SLT  = 4'h3;
  localparam logic [3:0] OP_MAC  = 4'h4;
  localparam logic [3:0] OP_HALT = 4'hB;
  localparam logic [3:0] OP_LD   = 4'hE;
  localparam logic [3:0] OP_ST   = 4'hF;

  // Low codes zero-extend to the ALU field; IDLE widens to all-ones
  typedef enum logic [1:0] {
    ALU_ADD  = 2'd0,
    ALU_MUL  = 2'd1,
    ALU_SLT  = 2'd2,
    ALU_IDLE = 2'd3
  } aluOp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXEC,
    ST_MAC,
    ST_MEM,
    ST_HALTED
  } state_e;

  typedef struct packed {
    logic   regWrite;
    logic   memToReg;
    logic   memWrite;
    logic   aluSrc;
    logic   regDst;
    aluOp_e alu1;
    aluOp_e alu2;
  } ctrlWord_t;

  localparam ctrlWord_t CW_IDLE = '{
    regWrite: 1'b0,
    memToReg: 1'b0,
    memWrite: 1'b0,
    aluSrc:   1'b0,
    regDst:   1'b0,
    alu1:     ALU_IDLE,
    alu2:     ALU_IDLE
  };

endpackage

// File: rtl/nn_ctrl_sequencer_if.sv
// Instruction handshake and control-word bundle.
// master = instruction issuer, slave = sequencer.
interface nn_ctrl_sequencer_if #(
  parameter int OPW  = 4,
  parameter int ALUW = 3
);
  logic            instr_valid;
  logic            instr_ready;
  logic [OPW-1:0]  opcode;
  logic            mem_ready;
  logic            ctrl_valid;
  logic            RegWrite;
  logic            MemtoReg;
  logic            MemWrite;
  logic            ALUSrc;
  logic            RegDst;
  logic [ALUW-1:0] ALUControl1;
  logic [ALUW-1:0] ALUControl2;
  logic            busy;
  logic            halted;
  logic            illegal;

  modport master (
    output instr_valid, opcode, mem_ready,
    input  instr_ready, ctrl_valid,
    input  RegWrite, MemtoReg, MemWrite,
    input  ALUSrc, RegDst,
    input  ALUControl1, ALUControl2,
    input  busy, halted, illegal
  );

  modport slave (
    input  instr_valid, opcode, mem_ready,
    output instr_ready, ctrl_valid,
    output RegWrite, MemtoReg, MemWrite,
    output ALUSrc, RegDst,
    output ALUControl1, ALUControl2,
    output busy, halted, illegal
  );
endinterface

// File: rtl/nn_ctrl_decode.sv
// Combinational opcode decoder.
// Produces the control word plus instruction-class flags.
module nn_ctrl_decode
  import nn_ctrl_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] opcode,
  output ctrlWord_t      word,
  output logic           is_mac,
  output logic           is_mem,
  output logic           is_halt,
  output logic           is_illegal
);

  always_comb begin
    word       = CW_IDLE;
    is_mac     = 1'b0;
    is_mem     = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    unique case (1'b1)
      opcode == OPW'(OP_NOP): ;
      opcode == OPW'(OP_ADD): begin
        word.regWrite = 1'b1;
        word.alu1     = ALU_ADD;
      end
      opcode == OPW'(OP_MUL): begin
        word.regWrite = 1'b1;
        word.alu1     = ALU_MUL;
      end
      opcode == OPW'(OP_SLT): begin
        word.regWrite = 1'b1;
        word.alu1     = ALU_SLT;
      end
      opcode == OPW'(OP_MAC): begin
        word.regWrite = 1'b1;
        word.alu1     = ALU_MUL;
        word.alu2     = ALU_ADD;
        is_mac        = 1'b1;
      end
      opcode == OPW'(OP_HALT): is_halt = 1'b1;
      opcode == OPW'(OP_LD): begin
        word.regWrite = 1'b1;
        word.memToReg = 1'b1;
        word.alu1     = ALU_ADD;
        is_mem        = 1'b1;
      end
      opcode == OPW'(OP_ST): begin
        word.memWrite = 1'b1;
        word.alu1     = ALU_ADD;
        is_mem        = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/nn_ctrl_sequencer.sv
// Multi-cycle NN control sequencer.
// Registers decoded control words and holds them for MAC/memory ops.
module nn_ctrl_sequencer
  import nn_ctrl_pkg::*;
#(
  parameter int OPW        = 4,
  parameter int ALUW       = 3,
  parameter int MAC_CYCLES = 2
) (
  input logic          clk,
  input logic          rst_n,
  nn_ctrl_sequencer_if.slave bus
);

  localparam int CNTW     = $clog2(MAC_CYCLES + 1);
  localparam bit MACMULTI = (MAC_CYCLES > 1);

  state_e          state;
  state_e          nextState;
  state_e          target;
  ctrlWord_t       word;
  ctrlWord_t       decWord;
  ctrlWord_t       cw;
  logic [CNTW-1:0] macCnt;
  logic            haltFlag;
  logic            illegalFlag;
  logic            isMac;
  logic            isMem;
  logic            isHalt;
  logic            isIllegal;
  logic            ready;
  logic            accept;
  logic            commit;
  logic            active;

  function automatic logic [ALUW-1:0] aluField(aluOp_e op);
    return (op == ALU_IDLE) ? '1 : ALUW'(op);
  endfunction

  nn_ctrl_decode #(
    .OPW(OPW)
  ) u_decode (
    .opcode    (bus.opcode),
    .word      (decWord),
    .is_mac    (isMac),
    .is_mem    (isMem),
    .is_halt   (isHalt),
    .is_illegal(isIllegal)
  );

  assign ready  = (state == ST_IDLE) || (state == ST_EXEC);
  assign accept = bus.instr_valid && ready;
  assign active = (state == ST_EXEC) || (state == ST_MAC)
               || (state == ST_MEM);

  always_comb begin
    target = ST_EXEC;
    unique case (1'b1)
      isHalt:           target = ST_HALTED;
      isMem:            target = ST_MEM;
      isMac && MACMULTI: target = ST_MAC;
      default: ;
    endcase
  end

  always_comb begin
    nextState = state;
    commit    = 1'b0;
    unique case (state)
      ST_IDLE: nextState = accept ? target : ST_IDLE;
      ST_EXEC: begin
        commit    = 1'b1;
        nextState = accept ? target : ST_IDLE;
      end
      ST_MAC: begin
        commit = (macCnt == CNTW'(1));
        if (commit) nextState = ST_IDLE;
      end
      ST_MEM: begin
        commit = bus.mem_ready;
        if (commit) nextState = ST_IDLE;
      end
      ST_HALTED: nextState = ST_HALTED;
      default:   nextState = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      word        <= CW_IDLE;
      macCnt      <= '0;
      haltFlag    <= 1'b0;
      illegalFlag <= 1'b0;
    end else begin
      state <= nextState;
      if (accept) word <= decWord;
      if (accept && isMac)
        macCnt <= CNTW'(MAC_CYCLES);
      else if (state == ST_MAC && macCnt != '0)
        macCnt <= macCnt - CNTW'(1);
      if (accept && isHalt)    haltFlag    <= 1'b1;
      if (accept && isIllegal) illegalFlag <= 1'b1;
    end
  end

  // Fields only leave the idle pattern while an instruction is in flight
  assign cw = active ? word : CW_IDLE;

  assign bus.instr_ready = ready;
  assign bus.ctrl_valid  = commit;
  assign bus.RegWrite    = commit && cw.regWrite;
  assign bus.MemtoReg    = cw.memToReg;
  assign bus.MemWrite    = cw.memWrite;
  assign bus.ALUSrc      = cw.aluSrc;
  assign bus.RegDst      = cw.regDst;
  assign bus.ALUControl1 = aluField(cw.alu1);
  assign bus.ALUControl2 = aluField(cw.alu2);
  assign bus.busy        = active;
  assign bus.halted      = haltFlag;
  assign bus.illegal     = illegalFlag;

endmodule

// File: tb/tb_nn_ctrl_sequencer.sv
// Testbench for nn_ctrl_sequencer.
// Per-cycle expectations come from a queue of planned output rows.
module tb_nn_ctrl_sequencer;

  localparam int MC = 3;

  typedef struct packed {
    logic       ready;
    logic       cvalid;
    logic       rw;
    logic       m2r;
    logic       mw;
    logic       aluSrc;
    logic       regDst;
    logic [2:0] alu1;
    logic [2:0] alu2;
    logic       busy;
    logic       halted;
    logic       illegal;
  } obs_t;

  typedef struct {
    bit         isMem;
    bit         memRdy;
    bit         ready;
    bit         commit;
    bit         rw;
    bit         m2r;
    bit         mw;
    logic [2:0] alu1;
    logic [2:0] alu2;
  } row_t;

  localparam obs_t RST = 16'b1000000_111_111_000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  row_t q[$];
  bit   haltedM = 0;
  bit   illegalM = 0;

  always #5 clk = ~clk;

  nn_ctrl_sequencer_if #(.OPW(4), .ALUW(3)) bus ();

  nn_ctrl_sequencer #(
    .OPW(4),
    .ALUW(3),
    .MAC_CYCLES(MC)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  function automatic obs_t sample();
    obs_t o;
    o.ready   = bus.instr_ready;
    o.cvalid  = bus.ctrl_valid;
    o.rw      = bus.RegWrite;
    o.m2r     = bus.MemtoReg;
    o.mw      = bus.MemWrite;
    o.aluSrc  = bus.ALUSrc;
    o.regDst  = bus.RegDst;
    o.alu1    = bus.ALUControl1;
    o.alu2    = bus.ALUControl2;
    o.busy    = bus.busy;
    o.halted  = bus.halted;
    o.illegal = bus.illegal;
    return o;
  endfunction

  function automatic row_t mkRow(bit c, bit w, logic [2:0] a1, logic [2:0] a2);
    row_t r;
    r.isMem = 0; r.memRdy = 0; r.ready = 1;
    r.commit = c; r.rw = w; r.m2r = 0; r.mw = 0;
    r.alu1 = a1; r.alu2 = a2;
    return r;
  endfunction

  // Expected behaviour of one accepted instruction, cycle by cycle
  task automatic plan(input logic [3:0] op, input int k);
    row_t r;
    case (op)
      4'h1: q.push_back(mkRow(1, 1, 3'b000, 3'b111));
      4'h2: q.push_back(mkRow(1, 1, 3'b001, 3'b111));
      4'h3: q.push_back(mkRow(1, 1, 3'b010, 3'b111));
      4'h0: q.push_back(mkRow(1, 0, 3'b111, 3'b111));
      4'h4: for (int i = 1; i <= MC; i++) begin
        r = mkRow(i == MC, i == MC, 3'b001, 3'b000);
        r.ready = (MC == 1);
        q.push_back(r);
      end
      4'hB: haltedM = 1;
      4'hE, 4'hF: for (int i = 0; i <= k; i++) begin
        r = mkRow(i == k, (op == 4'hE) && (i == k), 3'b000, 3'b111);
        r.ready = 0; r.isMem = 1; r.memRdy = (i == k);
        r.m2r = (op == 4'hE); r.mw = (op == 4'hF);
        q.push_back(r);
      end
      default: begin
        q.push_back(mkRow(1, 0, 3'b111, 3'b111));
        illegalM = 1;
      end
    endcase
  endtask

  // Called #1 after a rising edge; returns #1 after the next one
  task automatic step(input bit v, input logic [3:0] op, input int k,
                      output obs_t o, output obs_t e);
    row_t r;
    bit   have;
    have = (q.size() != 0);
    if (have) r = q[0];
    else begin
      r = mkRow(0, 0, 3'b111, 3'b111);
      r.ready = !haltedM;
    end
    bus.instr_valid = v;
    bus.opcode = op;
    if (have && r.isMem) bus.mem_ready = r.memRdy;
    else bus.mem_ready = 1'($urandom);
    e = {r.ready, r.commit, r.rw, r.m2r, r.mw, 1'b0, 1'b0,
         r.alu1, r.alu2, have, haltedM, illegalM};
    @(negedge clk);
    o = sample();
    @(posedge clk);
    if (have) void'(q.pop_front());
    if (v && r.ready) plan(op, k);
    #1;
  endtask

  task automatic doReset();
    rst_n = 0;
    bus.instr_valid = 0;
    bus.opcode = 4'h0;
    bus.mem_ready = 0;
    q.delete();
    haltedM = 0;
    illegalM = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    obs_t o, e;
    doReset();
    step(0, 4'h0, 0, o, e);
    checks++;
    if (o !== RST)
      $display("FAIL reset got=%h exp=%h", o, RST);
  endtask

  task automatic test_back_to_back();
    obs_t o, e;
    logic [3:0] ops[3] = '{4'h1, 4'h2, 4'h3};
    for (int i = 0; i < 5; i++) begin
      step(i < 3, ops[i % 3], 0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL b2b c%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_mac();
    obs_t o, e;
    for (int i = 0; i < MC + 4; i++) begin
      step(1, (i == 0) ? 4'h4 : 4'h1, 0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL mac c%0d got=%h exp=%h", i, o, e);
      end
    end
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(0, 4'h0, 0, o, e);
  endtask

  task automatic test_mem();
    obs_t o, e;
    logic [3:0] ops[3] = '{4'hE, 4'hF, 4'hE};
    int ks[3] = '{4, 4, 0};
    for (int t = 0; t < 3; t++) begin
      step(1, ops[t], ks[t], o, e);
      for (int i = 0; i < 20 && q.size() != 0; i++) begin
        step(0, 4'h0, 0, o, e);
        checks++;
        if (o !== e) begin
          failures++;
          $display("FAIL mem t%0d c%0d got=%h exp=%h", t, i, o, e);
        end
      end
    end
  endtask

  task automatic test_illegal();
    obs_t o, e;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, (i == 0) ? 4'h7 : 4'h1, 0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL illegal c%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [3:0] op;
    for (int i = 0; i < 300; i++) begin
      do op = 4'($urandom); while (op == 4'hB);
      step(($urandom % 4) != 0, op, $urandom_range(0, 3), o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL random c%0d op=%h got=%h exp=%h", i, op, o, e);
      end
    end
    for (int i = 0; i < 20 && q.size() != 0; i++)
      step(0, 4'h0, 0, o, e);
  endtask

  task automatic test_halt();
    obs_t o, e;
    for (int i = 0; i < 12; i++) begin
      step(1, (i == 0) ? 4'hB : 4'h1, 0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL halt c%0d got=%h exp=%h", i, o, e);
      end
    end
    doReset();
    step(0, 4'h0, 0, o, e);
    checks++;
    if (o !== RST) begin
      failures++;
      $display("FAIL halt_reset got=%h exp=%h", o, RST);
    end
  endtask

  task automatic test_reset_mid_mem();
    obs_t o, e;
    step(1, 4'hE, 5, o, e);
    step(0, 4'h0, 0, o, e);
    bus.mem_ready = 0;
    #2;
    o = sample();
    checks++;
    if (o.m2r !== 1'b1 || o.busy !== 1'b1) begin
      failures++;
      $display("FAIL pre_abort got=%h exp m2r=1 busy=1", o);
    end
    rst_n = 0;
    #1;
    o = sample();
    checks++;
    if (o !== RST) begin
      failures++;
      $display("FAIL abort got=%h exp=%h", o, RST);
    end
    bus.mem_ready = 1;
    #1;
    checks++;
    if (bus.ctrl_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_cv got=%b exp=0", bus.ctrl_valid);
    end
    q.delete();
    haltedM = 0;
    illegalM = 0;
    bus.mem_ready = 0;
    @(posedge clk);
    @(negedge clk) rst_n = 1;
    @(posedge clk);
    #1;
    step(1, 4'hE, 1, o, e);
    for (int i = 0; i < 20 && q.size() != 0; i++) begin
      step(0, 4'h0, 0, o, e);
      checks++;
      if (o !== e) begin
        failures++;
        $display("FAIL after_abort c%0d got=%h exp=%h", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mac();
    test_mem();
    test_illegal();
    test_random();
    test_halt();
    test_reset_mid_mem();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end

endmodule

●

// File: doc/nn_ctrl_sequencer.md
# nn_ctrl_sequencer

Parametrised, multi-cycle successor to the single-cycle opcode decoder in the NN processor datapath. It accepts opcodes over a valid/ready handshake and drives registered control words to the ALU pair, register file and data memory. It holds those control words for the duration of multi-cycle MAC and memory operations. It also latches HALT and illegal-opcode conditions instead of aborting simulation.

## Interface
Parameters:
- OPW, 4, opcode width
- ALUW, 3, width of each ALU control field
- MAC_CYCLES, 2, cycles a MAC occupies the ALU pair (≥1; 1 = single-cycle)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- instr_valid  in  1  opcode present
- instr_ready  out  1  sequencer can accept an opcode this cycle
- opcode  in  OPW  0x0 NOP, 0x1 ADD, 0x2 MUL, 0x3 SLT, 0x4 MAC, 0xB HALT, 0xE LD, 0xF ST; all others illegal
- mem_ready  in  1  data memory completes the LD/ST presented this cycle
- ctrl_valid  out  1  final (commit) cycle of the current instruction
- RegWrite, MemtoReg, MemWrite, ALUSrc, RegDst  out  1 each  control bits
- ALUControl1, ALUControl2  out  ALUW each  ALU op selects; all-ones = idle
- busy  out  1  an instruction is in flight
- halted  out  1  HALT retired; sticky until reset
- illegal  out  1  an illegal opcode was accepted; sticky until reset

## Operation
- States: IDLE, EXEC, MAC, MEM, HALTED. Reset state is IDLE.
- Accept condition: instr_valid && instr_ready. The decoded control word is registered on the accepting edge.
- instr_ready is 1 in IDLE. It is also 1 in EXEC, which allows back-to-back acceptance. It is 0 in MAC, MEM and HALTED.
- ADD, MUL, SLT, NOP and illegal opcodes go to EXEC for exactly one cycle.
  - ctrl_valid is 1 in that cycle. RegWrite is 1 for ADD, MUL and SLT.
  - On leaving EXEC, the next state is the state of any newly accepted opcode, else IDLE.
- MAC: ALUControl1=001, ALUControl2=000.
  - Held for MAC_CYCLES cycles by a down-counter of width $clog2(MAC_CYCLES+1).
  - RegWrite and ctrl_valid are asserted only in the last of those cycles.
  - When MAC_CYCLES=1, MAC behaves like EXEC.
- LD: ALUControl1=000, MemtoReg=1. ST: ALUControl1=000, MemWrite=1.
  - Both stay in MEM with all fields held until mem_ready=1.
  - ctrl_valid is asserted in the mem_ready cycle; RegWrite is also asserted in that cycle for LD.
  - No timeout.
- HALT: go to HALTED on acceptance. halted=1 from the next cycle. All enables are 0 and ALU fields all-ones. Only reset exits HALTED.
- Illegal opcode: executes as a NOP and sets illegal=1 from the next cycle. Sequencing continues.
- Field values in every non-commit cycle: RegWrite=0. ALUSrc=0 and RegDst=0 always in this generation; the fields are reserved for immediate forms.
- With no instruction in flight, all enables are 0, ALU fields are all-ones and ctrl_valid=0.
- busy = (state is EXEC, MAC or MEM).

## Timing
- Reset (async assert, sync release): state=IDLE. All 1-bit outputs are 0 except instr_ready=1. ALUControl1 and ALUControl2 are all-ones. The counter and sticky flags are cleared.
- Latency from acceptance to first control cycle is 1 cycle. Commit occurs:
  - EXEC: at +1
  - MAC: at +MAC_CYCLES
  - MEM: at +1+k, where k is the number of cycles mem_ready stays low
- Throughput: one single-cycle instruction per clock.
- instr_ready depends only on state (Moore), with no combinational path from instr_valid.
- An opcode accepted while EXEC commits begins its control cycle on the next clock, with no bubble.
- mem_ready is ignored outside MEM.
- If mem_ready is already 1 in the first MEM cycle, the operation commits in that cycle.
- rst_n asserted mid-MAC or mid-MEM aborts the operation immediately. No commit pulse is produced.

## Structure
- Shared package nn_ctrl_pkg holds:
  - opcode localparams
  - ALU op encodings (ADD 000, MUL 001, SLT 010, IDLE all-ones)
  - the state enum
  - a packed control-word struct
- Sub-module nn_ctrl_decode: purely combinational opcode → control word plus is_mac, is_mem, is_halt and is_illegal flags. It is instantiated once, in front of the control-word register.

## Test plan
- Reset, then ADD, MUL, SLT presented back-to-back with instr_valid held high → commits on 3 consecutive cycles, ALUControl1 = 000/001/010, RegWrite=1 each, instr_ready stays 1.
- MAC with MAC_CYCLES=3 → ALUControl1=001, ALUControl2=000 held 3 cycles; ctrl_valid and RegWrite high only in cycle 3; instr_ready=0 for cycles 1–3.
- LD with mem_ready low for 4 cycles → MemtoReg=1 held 5 cycles; RegWrite and ctrl_valid only in the 5th cycle. Repeat with ST → MemWrite=1 held, RegWrite never asserted.
- Opcode 0x7, then ADD → illegal=1 from the cycle after acceptance and sticky; the ADD still commits normally.
- HALT, then instr_valid held with ADD → halted=1, instr_ready=0 indefinitely, no further ctrl_valid. rst_n pulse → IDLE, halted=0.
- rst_n asserted during the 2nd cycle of an LD wait → outputs immediately at reset values, no ctrl_valid. The next LD after release completes normally.
